// File: rtl/imm_materializer_pkg.sv
// Shared opcodes, extender codes and types for the constant materializer.
package imm_materializer_pkg;

  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // Must stay bit-compatible with the core's immediate extender.
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  typedef enum logic [1:0] {
    RULE_ADDIU,
    RULE_ORI,
    RULE_LUI,
    RULE_PAIR
  } rule_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_EMIT_HI
  } state_e;

  typedef struct packed {
    rule_e       rule;
    logic [15:0] hi;
    logic [15:0] lo;
  } cls_t;

  function automatic logic [31:0] itype(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/imm_materializer_classify.sv
// Picks the shortest rebuild rule for a 32-bit constant.
module imm_classify
  import imm_materializer_pkg::*;
(
  input  logic [31:0] d_i,
  output cls_t        cls_o
);

  logic r1, r2, r3;

  // Conditions made exclusive so first-match priority holds.
  assign r1 = (&d_i[31:15]) | ~(|d_i[31:15]);
  assign r2 = ~r1 & ~(|d_i[31:16]);
  assign r3 = ~r1 & ~r2 & ~(|d_i[15:0]);

  always_comb begin
    cls_o.hi   = d_i[31:16];
    cls_o.lo   = d_i[15:0];
    cls_o.rule = RULE_PAIR;
    unique case (1'b1)
      r1:      cls_o.rule = RULE_ADDIU;
      r2:      cls_o.rule = RULE_ORI;
      r3:      cls_o.rule = RULE_LUI;
      default: cls_o.rule = RULE_PAIR;
    endcase
  end

endmodule

// File: rtl/imm_materializer.sv
// Turns a constant + rt into one or two MIPS I-type beats
// (ADDIU / ORI / LUI / LUI+ORI) on a valid/ready stream.
module imm_materializer
  import imm_materializer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [4:0]       in_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_ext_op,
  output logic             out_last,
  output logic [CNT_W-1:0] emit_count
);

  state_e           state_q;
  logic [31:0]      instr_q;
  logic [1:0]       ext_q;
  logic             last_q;
  logic             valid_q;
  logic [15:0]      lo_q;
  logic [4:0]       rt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  cls_t        cls;
  logic [31:0] beat_instr;
  logic [1:0]  beat_ext;
  logic        accept;
  logic        fire;

  imm_classify u_cls (
    .d_i   (in_data),
    .cls_o (cls)
  );

  assign in_ready = (state_q != S_EMIT_HI)
                  && ((state_q != S_EMIT) || out_ready);
  assign accept   = in_valid && in_ready;
  assign fire     = valid_q && out_ready;
  assign cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // First beat of whatever sequence the new constant needs.
  always_comb begin
    beat_instr = itype(OP_LUI, 5'd0, in_rt, cls.hi);
    beat_ext   = EXT_LUI;
    unique case (cls.rule)
      RULE_ADDIU: begin
        beat_instr = itype(OP_ADDIU, 5'd0, in_rt, cls.lo);
        beat_ext   = EXT_SIGN;
      end
      RULE_ORI: begin
        beat_instr = itype(OP_ORI, 5'd0, in_rt, cls.lo);
        beat_ext   = EXT_ZERO;
      end
      default: begin
        beat_instr = itype(OP_LUI, 5'd0, in_rt, cls.hi);
        beat_ext   = EXT_LUI;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      ext_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      lo_q    <= '0;
      rt_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (fire) cnt_q <= cnt_d;
      unique case (state_q)
        S_EMIT_HI: begin
          if (out_ready) begin
            instr_q <= itype(OP_ORI, rt_q, rt_q, lo_q);
            ext_q   <= EXT_ZERO;
            last_q  <= 1'b1;
            state_q <= S_EMIT;
          end
        end
        default: begin
          if (state_q == S_EMIT && out_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
          if (accept) begin
            instr_q <= beat_instr;
            ext_q   <= beat_ext;
            valid_q <= 1'b1;
            lo_q    <= cls.lo;
            rt_q    <= in_rt;
            last_q  <= (cls.rule != RULE_PAIR);
            state_q <= (cls.rule == RULE_PAIR) ? S_EMIT_HI : S_EMIT;
          end
        end
      endcase
    end
  end

  assign out_valid  = valid_q;
  assign out_instr  = instr_q;
  assign out_ext_op = ext_q;
  assign out_last   = last_q;
  assign emit_count = cnt_q;

endmodule

// File: tb/tb_imm_materializer.sv
// Directed + randomized round-trip bench for imm_materializer.
module tb_imm_materializer;

  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_SIGN = 2'b01;
  localparam logic [1:0] X_LUI  = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_rt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [1:0]  out_ext_op;
  logic        out_last;
  logic [15:0] emit_count;

  imm_materializer #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_rt      (in_rt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_ext_op (out_ext_op),
    .out_last   (out_last),
    .emit_count (emit_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic beat(string tag, logic [31:0] ins, logic [1:0] ext,
                      logic last);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, out_instr, ins);
    check({tag, "_ext"}, {30'd0, out_ext_op}, {30'd0, ext});
    check({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
  endtask

  function automatic int nbeats(logic [31:0] d);
    int s;
    s = $signed(d);
    if (s >= -32768 && s <= 32767) return 1;
    if (d <= 32'h0000_FFFF) return 1;
    if (d[15:0] == 16'h0) return 1;
    return 2;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rt;
  } item_t;

  item_t       exp_q[$];
  logic [31:0] regs[32];
  bit          mon_en = 1'b0;
  bit          rand_rdy = 1'b0;
  int          seq_beats = 0;
  int          hs = 0;

  // Handshakes as seen from outside, for the final emit_count check.
  always @(negedge clk) begin
    if (rst) hs = 0;
    else if (out_valid && out_ready) hs++;
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Execute each handed-off beat on an architectural register model.
  always @(negedge clk) begin
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic [31:0] xv, a, r;
    item_t       it;
    if (mon_en && !rst && out_valid && out_ready) begin
      op  = out_instr[31:26];
      rs  = out_instr[25:21];
      rt  = out_instr[20:16];
      imm = out_instr[15:0];
      case (out_ext_op)
        X_SIGN:  xv = {{16{imm[15]}}, imm};
        X_ZERO:  xv = {16'h0, imm};
        X_LUI:   xv = {imm, 16'h0};
        default: xv = 32'hDEAD_BEEF;
      endcase
      a = (rs == 5'd0) ? 32'd0 : regs[rs];
      case (op)
        6'h09:   r = a + xv;
        6'h0D:   r = a | xv;
        6'h0F:   r = xv;
        default: r = 32'hBAD0_BAD0;
      endcase
      if (rt != 5'd0) regs[rt] = r;
      seq_beats++;
      if (out_last) begin
        if (exp_q.size() == 0) begin
          check("rt_unexpected_seq", 32'd1, 32'd0);
        end else begin
          it = exp_q.pop_front();
          check("rt_value", regs[it.rt], it.d);
          check("rt_beats", seq_beats, nbeats(it.d));
        end
        seq_beats = 0;
      end else if (seq_beats > 1) begin
        check("rt_too_many_beats", seq_beats, 32'd1);
      end
    end
  end

  task automatic send(logic [31:0] d, logic [4:0] rt);
    int n;
    item_t it;
    in_valid = 1'b1;
    in_data  = d;
    in_rt    = rt;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 1000);
    if (!in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    it.d  = d;
    it.rt = rt;
    exp_q.push_back(it);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  logic [31:0] bd[4];
  logic [4:0]  brt[4];
  logic [31:0] bi[4];
  logic [1:0]  bx[4];
  logic [31:0] corner[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bd  = '{32'h0000_0005, 32'hFFFF_8000, 32'h0000_8000, 32'h1234_0000};
    brt = '{5'd8, 5'd9, 5'd10, 5'd11};
    bi  = '{32'h2408_0005, 32'h2409_8000, 32'h340A_8000, 32'h3C0B_1234};
    bx  = '{X_SIGN, X_SIGN, X_ZERO, X_LUI};
    corner = '{32'h0, 32'h7FFF, 32'h8000, 32'hFFFF,
               32'h1_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    foreach (regs[i]) regs[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_emit_count", {16'd0, emit_count}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);

    // Back-to-back single-beat constants, no bubbles
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = bd[0];
    in_rt     = brt[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) begin
        in_data = bd[i+1];
        in_rt   = brt[i+1];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      beat($sformatf("b2b%0d", i), bi[i], bx[i], 1'b1);
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      check("b2b_count", {16'd0, emit_count}, i);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_count_end", {16'd0, emit_count}, 32'd4);
    check("b2b_idle", {31'd0, out_valid}, 32'd0);

    // Two-beat constant with a 3-cycle consumer stall on the LUI beat
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    in_rt     = 5'd12;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      beat("stall_hi", 32'h3C0C_1234, X_LUI, 1'b0);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    beat("pair_lo", 32'h358C_5678, X_ZERO, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pair_count", {16'd0, emit_count}, 32'd6);
    check("pair_idle", {31'd0, out_valid}, 32'd0);

    // Reset with the ORI half still pending
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    in_rt    = 5'd12;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_count", {16'd0, emit_count}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_instr", out_instr, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_rst_no_ori", {31'd0, out_valid}, 32'd0);
    end

    // rt = 0 is encoded as given
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'h0000_0007;
    in_rt    = 5'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    beat("rt0", 32'h2400_0007, X_SIGN, 1'b1);
    @(posedge clk);
    #1;

    // Randomized round-trip through the extender/ALU model
    exp_q.delete();
    seq_beats = 0;
    mon_en    = 1'b1;
    rand_rdy  = 1'b1;
    foreach (corner[i]) send(corner[i], 5'($urandom_range(1, 31)));
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] d;
      logic [15:0] t;
      t = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = {16'h0, t};
        2:       d = {t, 16'h0};
        default: d = {{16{t[15]}}, t};
      endcase
      send(d, 5'($urandom_range(1, 31)));
    end
    begin
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 20000) begin
        @(negedge clk);
        n++;
      end
      check("drain_timeout", {31'd0, (exp_q.size() != 0 || out_valid)},
            32'd0);
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    check("emit_count_total", {16'd0, emit_count}, {16'd0, hs[15:0]});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
